wb_stream_writer: RTL and testbench

WB_STREAM_WRITER -- requirements
Module: wb_stream_writer

---
 rtl/wb_stream_writer.sv | 234 +++++++++++++++++++++++
 tb/tb_wb_stream_writer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_writer.sv
// Stream-to-Wishbone burst writer: pulls 32-bit words from a valid/ready source and writes them to consecutive word addresses.
// Latency: one cycle to fetch a word, then one Wishbone write held until ack (optional read-back check adds one gap plus one read).
// Backpressure: s_ready is high only while fetching; the bus is held until ack; a stall or ack timeout aborts with a sticky error.
// Optional feature: define WB_WRITER_READBACK_EN to read back and compare every written word.
module wb_stream_writer #(
  parameter int WB_ADDR_WIDTH = 12,
  parameter int LEN_WIDTH     = 10,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst,
  input  logic                     start_i,
  input  logic [WB_ADDR_WIDTH-1:0] base_adr_i,
  input  logic [LEN_WIDTH-1:0]     len_i,
  input  logic [31:0]              s_dat_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]              wb_dat_o,
  output logic [3:0]               wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_stb_o,
  output logic                     wb_cyc_o,
  input  logic [31:0]              wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_stall_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  // Timeout counter holds 0 .. ACK_TIMEOUT-1 strobe cycles.
  localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
`ifdef WB_WRITER_READBACK_EN
    WRITE = 2'd2,
    CHECK = 2'd3
`else
    WRITE = 2'd2
`endif
  } state_t;

  state_t                   state, state_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q;
  logic [LEN_WIDTH-1:0]     cnt_q;
  logic [31:0]              dat_q;
  logic                     err_q;
  logic                     done_q;
  logic [TMO_W-1:0]         tmo_q;

  // Control strobes from the next-state logic to the datapath.
  logic ld;        // latch base address and length
  logic adv;       // word finished: step address, decrement count
  logic cap;       // capture source word
  logic set_err;
  logic clr_err;
  logic done_d;
  logic stb;
  logic we;
  logic rdy;
  logic last;
  logic tmo_hit;

  assign last    = (cnt_q == LEN_WIDTH'(1));
  assign tmo_hit = (tmo_q == TMO_LAST);

`ifdef WB_WRITER_READBACK_EN
  // Read phase of CHECK; the first CHECK cycle keeps stb low so no strobe follows an ack.
  logic rd_q;
  logic rd_match;
  assign rd_match = (wb_dat_i == dat_q);
`else
  logic unused_rd_dat;
  assign unused_rd_dat = ^wb_dat_i;
`endif

  // State register.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, bus control and datapath strobes.
  always_comb begin
    state_d = state;
    ld      = 1'b0;
    adv     = 1'b0;
    cap     = 1'b0;
    set_err = 1'b0;
    clr_err = 1'b0;
    done_d  = 1'b0;
    stb     = 1'b0;
    we      = 1'b0;
    rdy     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          clr_err = 1'b1;
          if (len_i != '0) begin
            ld      = 1'b1;
            state_d = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        rdy = 1'b1;
        if (s_valid_i) begin
          cap     = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        stb = 1'b1;
        we  = 1'b1;
        if (wb_stall_i) begin
          set_err = 1'b1;
          state_d = IDLE;
        end else if (wb_ack_i) begin
`ifdef WB_WRITER_READBACK_EN
          state_d = CHECK;
`else
          adv = 1'b1;
          if (last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
`endif
        end else if (tmo_hit) begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef WB_WRITER_READBACK_EN
      CHECK: begin
        if (rd_q) begin
          stb = 1'b1;
          if (wb_stall_i) begin
            set_err = 1'b1;
            state_d = IDLE;
          end else if (wb_ack_i) begin
            if (!rd_match) begin
              set_err = 1'b1;
              state_d = IDLE;
            end else begin
              adv = 1'b1;
              if (last) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = FETCH;
              end
            end
          end else if (tmo_hit) begin
            set_err = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: address/count, write data, error flag, done pulse and ack timeout.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      adr_q  <= '0;
      cnt_q  <= '0;
      dat_q  <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      tmo_q  <= '0;
    end else begin
      done_q <= done_d;
      if (ld) begin
        adr_q <= {base_adr_i[WB_ADDR_WIDTH-1:2], 2'b00};
        cnt_q <= len_i;
      end else if (adv) begin
        adr_q <= adr_q + WB_ADDR_WIDTH'(4);
        cnt_q <= cnt_q - LEN_WIDTH'(1);
      end
      if (cap) begin
        dat_q <= s_dat_i;
      end
      if (clr_err) begin
        err_q <= 1'b0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
      // Count only while the same strobe stays outstanding; any exit restarts it.
      if (stb && (state_d == state)) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end else begin
        tmo_q <= '0;
      end
    end
  end

`ifdef WB_WRITER_READBACK_EN
  // Read strobe starts on the second CHECK cycle.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      rd_q <= 1'b0;
    end else begin
      rd_q <= (state == CHECK);
    end
  end
`endif

  assign s_ready_o = rdy;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = stb ? 4'hF : 4'h0;
  assign wb_we_o   = we;
  assign wb_stb_o  = stb;
  assign wb_cyc_o  = stb;
  assign busy_o    = (state != IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_wb_stream_writer.sv
// Self-checking bench for wb_stream_writer: table-driven scenarios, random bursts, reset corner cases.
// Slave, source and monitors all act on the falling clock edge from one process.
// Expected writes come from the address/data rules, not from the design's internals.
module tb_wb_stream_writer;

  localparam int AW = 12;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic          start_i;
  logic [AW-1:0] base_adr_i;
  logic [9:0]    len_i;
  logic [31:0]   s_dat_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o, wb_stb_o, wb_cyc_o;
  logic [31:0]   wb_dat_i;
  logic          wb_ack_i, wb_stall_i;
  logic          busy_o, done_o, err_o;

  always #5 wb_clk = ~wb_clk;

  wb_stream_writer dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start_i(start_i), .base_adr_i(base_adr_i),
    .len_i(len_i), .s_dat_i(s_dat_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_stall_i(wb_stall_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {9'd0, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
            s_ready_o, busy_o, done_o, err_o};
  endfunction

  // Slave behaviour knobs.
  int ack_dly, stall_word, never_ack, corrupt;
  int widx, cur_idx, scount;
  logic prev_stb, prev_ack, hs_pend;
  logic [AW-1:0] prev_adr;
  logic [31:0] prev_dat;

  typedef struct {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
  } wr_t;

  logic [31:0] src_q[$];
  logic [31:0] words[$];
  wr_t         wr_log[$];
  logic [31:0] mem[int];
  int done_cnt, stb_cycles, run_len, max_run;
  bit busy_seen;

  // One clock cycle: monitor outputs, answer the bus, drive the source.
  task automatic tick();
    @(negedge wb_clk);
    if (hs_pend && src_q.size() > 0) void'(src_q.pop_front());
    if (done_o) done_cnt++;
    if (busy_o) busy_seen = 1'b1;
    if (prev_ack) check("stb_after_ack", {63'd0, wb_stb_o}, 64'd0);
    if (wb_stb_o) begin
      stb_cycles++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      check("sel_full", {60'd0, wb_sel_o}, 64'hF);
      check("cyc_with_stb", {63'd0, wb_cyc_o}, 64'd1);
`ifndef WB_WRITER_READBACK_EN
      check("we_with_stb", {63'd0, wb_we_o}, 64'd1);
`endif
      if (prev_stb) begin
        check("adr_hold", {52'd0, wb_adr_o}, {52'd0, prev_adr});
        check("dat_hold", {32'd0, wb_dat_o}, {32'd0, prev_dat});
      end
    end else begin
      run_len = 0;
    end
    wb_ack_i   = 1'b0;
    wb_stall_i = 1'b0;
    if (wb_stb_o) begin
      if (!prev_stb) begin
        scount = 0;
        if (wb_we_o) begin
          cur_idx = widx;
          widx++;
        end else begin
          cur_idx = -1;
        end
      end
      scount++;
      if (never_ack == 0 && scount == ack_dly + 1) begin
        if (wb_we_o && cur_idx == stall_word) begin
          wb_stall_i = 1'b1;
        end else begin
          wb_ack_i = 1'b1;
          if (wb_we_o) begin
            wr_log.push_back('{wb_adr_o, wb_dat_o, wb_sel_o});
            mem[int'(wb_adr_o)] = wb_dat_o;
          end else if (corrupt != 0) begin
            wb_dat_i = 32'hDEAD;
          end else if (mem.exists(int'(wb_adr_o))) begin
            wb_dat_i = mem[int'(wb_adr_o)];
          end else begin
            wb_dat_i = 32'h0;
          end
        end
      end
    end
    prev_ack = wb_ack_i;
    prev_stb = wb_stb_o;
    prev_adr = wb_adr_o;
    prev_dat = wb_dat_o;
    if (src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      s_valid_i = 1'b1;
      s_dat_i   = src_q[0];
    end else begin
      s_valid_i = 1'b0;
      s_dat_i   = $urandom;
    end
    hs_pend = s_valid_i && s_ready_o;
  endtask

  // One burst from start to idle; source words are taken from 'words'.
  task automatic run_txn(input string tag, input logic [AW-1:0] base, input int len,
                         input int dly, input int stw, input int nev,
                         input int e_err, input int e_done, input int e_wr);
    logic [AW-1:0] e_adr;
    ack_dly = dly; stall_word = stw; never_ack = nev; widx = 0;
    wr_log.delete();
    src_q = words;
    done_cnt = 0; stb_cycles = 0; max_run = 0; run_len = 0; busy_seen = 1'b0;
    start_i = 1'b1; base_adr_i = base; len_i = 10'(len);
    tick();
    start_i = 1'b0;
    check({tag, "_err_clear"}, {63'd0, err_o}, 64'd0);
    for (int c = 0; c < 400 && busy_o; c++) begin
      tick();
      // Starts while busy must be ignored.
      if (busy_o && $urandom_range(0, 3) == 0) begin
        start_i = 1'b1; len_i = 10'($urandom); base_adr_i = AW'($urandom);
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    check({tag, "_finished"}, {63'd0, busy_o}, 64'd0);
    tick();
    tick();
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'(e_done));
    check({tag, "_err"}, {63'd0, err_o}, 64'(e_err));
    check({tag, "_nwrites"}, 64'(wr_log.size()), 64'(e_wr));
    if (len == 0) begin
      check({tag, "_busy_seen"}, {63'd0, busy_seen}, 64'd0);
      check({tag, "_stb_cycles"}, 64'(stb_cycles), 64'd0);
    end
    if (nev != 0) check({tag, "_tmo_cycles"}, 64'(max_run), 64'd15);
    for (int i = 0; i < e_wr && i < wr_log.size(); i++) begin
      e_adr = {base[AW-1:2], 2'b00} + AW'(4 * i);
      check({tag, "_adr"}, {52'd0, wr_log[i].adr}, {52'd0, e_adr});
      check({tag, "_dat"}, {32'd0, wr_log[i].dat}, {32'd0, words[i]});
      check({tag, "_sel"}, {60'd0, wr_log[i].sel}, 64'hF);
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int len, dly, stw, nev;
    logic [31:0] w0;
    int e_err, e_done, e_wr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{12'h010, 3, 1, -1, 0, 32'hA1, 0, 1, 3};  // basic burst
    tbl[1] = '{12'h100, 0, 1, -1, 0, 32'h0,  0, 1, 0};  // zero length
    tbl[2] = '{12'hFFC, 2, 1, -1, 0, 32'h11, 0, 1, 2};  // address wrap
    tbl[3] = '{12'h200, 3, 2,  1, 0, 32'h21, 1, 0, 1};  // stall on second word
    tbl[4] = '{12'h300, 2, 1, -1, 1, 32'h31, 1, 0, 0};  // never acked
    tbl[5] = '{12'h7FF, 2, 3, -1, 0, 32'h41, 0, 1, 2};  // low address bits ignored

    wb_rst = 1'b1; start_i = 1'b0; base_adr_i = '0; len_i = '0;
    s_dat_i = '0; s_valid_i = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
    ack_dly = 1; stall_word = -1; never_ack = 0; corrupt = 0;
    widx = 0; cur_idx = -1; scount = 0;
    prev_stb = 1'b0; prev_ack = 1'b0; hs_pend = 1'b0; prev_adr = '0; prev_dat = '0;

    tick();
    check("reset_outs", outs(), 64'd0);
    tick();
    wb_rst = 1'b0;
    tick();
    check("post_reset_outs", outs(), 64'd0);

    for (int t = 0; t < 6; t++) begin
      words.delete();
      for (int i = 0; i < tbl[t].len; i++) words.push_back(tbl[t].w0 + 32'(i));
      run_txn($sformatf("vec%0d", t), tbl[t].base, tbl[t].len, tbl[t].dly, tbl[t].stw,
              tbl[t].nev, tbl[t].e_err, tbl[t].e_done, tbl[t].e_wr);
    end

    // Random bursts against the rule-based expectation.
    for (int t = 0; t < 24; t++) begin
      int len, dly, mode, stw, nev, e_wr;
      logic [AW-1:0] base;
      base = AW'($urandom);
      len  = $urandom_range(1, 5);
      dly  = $urandom_range(1, 3);
      mode = $urandom_range(0, 9);
      stw  = (mode == 0) ? $urandom_range(0, len - 1) : -1;
      nev  = (mode == 1) ? 1 : 0;
      words.delete();
      for (int i = 0; i < len; i++) words.push_back($urandom);
      e_wr = (nev != 0) ? 0 : ((stw >= 0) ? stw : len);
      run_txn($sformatf("rnd%0d", t), base, len, dly, stw, nev,
              (nev != 0 || stw >= 0) ? 1 : 0, (nev != 0 || stw >= 0) ? 0 : 1, e_wr);
    end

`ifdef WB_WRITER_READBACK_EN
    words.delete();
    words.push_back(32'hBEEF);
    corrupt = 1;
    run_txn("rb_bad", 12'h080, 1, 1, -1, 0, 1, 0, 1);
    corrupt = 0;
    run_txn("rb_ok", 12'h084, 1, 1, -1, 0, 0, 1, 1);
`endif

    // Reset asserted while a write strobe is outstanding.
    never_ack = 1; stall_word = -1; widx = 0;
    words.delete();
    words.push_back(32'h1);
    words.push_back(32'h2);
    src_q = words;
    start_i = 1'b1; base_adr_i = 12'h040; len_i = 10'd2;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 30 && !wb_stb_o; c++) tick();
    tick();
    check("mid_write_stb", {63'd0, wb_stb_o}, 64'd1);
    #2 wb_rst = 1'b1;
    #1 check("rst_async", outs(), 64'd0);
    tick();
    check("rst_hold", outs(), 64'd0);
    wb_rst = 1'b0;
    src_q.delete();
    tick();
    check("rst_idle", outs(), 64'd0);
    never_ack = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
